// File: rtl/pipe_buffer_chain_pkg.sv
// rtl/pipe_buffer_chain_pkg.sv - shared widths and control-bundle bit indices for the pipeline chain
package pipe_buffer_chain_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_STAGES = 3;

    // Bit positions inside the control bundle, shared with the datapath and control unit
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_OP_LO  = 4;
    localparam int CTRL_ALU_OP_HI  = 7;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
    } ctrl_t;

    function automatic logic [DEF_CTRL_W-1:0] pack_ctrl(input ctrl_t c);
        return DEF_CTRL_W'(c);
    endfunction

endpackage

// File: rtl/pipe_buffer_chain_if.sv
// rtl/pipe_buffer_chain_if.sv - valid/ready beat carrying a data word and a control bundle
interface pipe_buffer_chain_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_buffer_chain_stage_cell.sv
// rtl/pipe_buffer_chain_stage_cell.sv - one valid/data/ctrl register with load, hold, clear and bubble zeroing
module pipe_stage_cell
    import pipe_buffer_chain_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    input  logic [CTRL_W-1:0] src_ctrl,
    output logic              v,
    output logic [DATA_W-1:0] d,
    output logic [CTRL_W-1:0] c
);

    // Data is left untouched by bubbles and clears so the wide word only toggles on real beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= 1'b0;
            d <= '0;
            c <= '0;
        end else if (clear) begin
            v <= 1'b0;
            c <= '0;
        end else if (load) begin
            v <= src_valid;
            if (src_valid) begin
                d <= src_data;
                c <= src_ctrl;
            end else begin
                c <= '0;
            end
        end
    end

endmodule

// File: rtl/pipe_buffer_chain.sv
// rtl/pipe_buffer_chain.sv - elastic pipeline-register chain with stall, flush and occupancy count
module pipe_buffer_chain
    import pipe_buffer_chain_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int STAGES = DEF_STAGES,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_buffer_chain_if.slave   up,
    pipe_buffer_chain_if.master  dn,
    input  logic                 stall,
    input  logic                 flush,
    output logic [OCC_W-1:0]     occupancy
);

    logic [STAGES-1:0] v;
    logic [DATA_W-1:0] d [STAGES];
    logic [CTRL_W-1:0] c [STAGES];
    logic [STAGES-1:0] adv;
    logic              push;
    logic              pop;

    // A stage may advance if the one after it advances or it holds only a bubble
    always_comb begin
        logic a;
        adv = '0;
        a = dn.ready | ~v[STAGES-1];
        adv[STAGES-1] = a;
        for (int k = STAGES - 2; k >= 0; k--) begin
            a = a | ~v[k];
            adv[k] = a;
        end
    end

    assign up.ready = adv[0] & ~stall & ~flush & rst_n;
    assign push     = up.valid & up.ready;
    assign pop      = v[STAGES-1] & dn.ready & ~stall & ~flush & rst_n;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              src_valid;
        logic [DATA_W-1:0] src_data;
        logic [CTRL_W-1:0] src_ctrl;

        if (k == 0) begin : g_head
            assign src_valid = push;
            assign src_data  = up.data;
            assign src_ctrl  = up.ctrl;
        end else begin : g_body
            assign src_valid = v[k-1];
            assign src_data  = d[k-1];
            assign src_ctrl  = c[k-1];
        end

        pipe_stage_cell #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (adv[k] & ~stall),
            .clear     (flush),
            .src_valid (src_valid),
            .src_data  (src_data),
            .src_ctrl  (src_ctrl),
            .v         (v[k]),
            .d         (d[k]),
            .c         (c[k])
        );
    end

    assign dn.valid = v[STAGES-1];
    assign dn.data  = d[STAGES-1];
    // A bubble must never present RegWrite/MemWrite downstream
    assign dn.ctrl  = v[STAGES-1] ? c[STAGES-1] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (!stall) begin
            occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule
